// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 access codes,
// FSM state encoding and the data width.
package dmem_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  // Stores only have signed-less B/H/W forms; loads add the unsigned B/H variants.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
           (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane steering for RV32I loads/stores: byte enables, replicated store
// data, sign/zero-extended load data and the natural-alignment check.
module mem_align
  import dmem_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addr_lo,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [XLEN-1:0] i_rword,
  output logic [3:0]      o_byte_en,
  output logic [XLEN-1:0] o_store_word,
  output logic [XLEN-1:0] o_load_data,
  output logic            o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rword[8*i_addr_lo +: 8];
  assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

  // NOTE: every output gets a default first so no path through the case infers a latch.
  always_comb begin
    o_byte_en    = 4'b0000;
    o_store_word = i_wdata;
    o_load_data  = '0;
    o_misalign   = 1'b0;
    case (i_funct3)
      F3_B: begin
        o_byte_en    = 4'b0001 << i_addr_lo;
        o_store_word = {4{i_wdata[7:0]}};
        o_load_data  = {{24{w_byte[7]}}, w_byte};
      end
      F3_BU: o_load_data = {24'd0, w_byte};
      F3_H: begin
        o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
        o_store_word = {2{i_wdata[15:0]}};
        o_load_data  = {{16{w_half[15]}}, w_half};
        o_misalign   = i_addr_lo[0];
      end
      F3_HU: begin
        o_load_data = {16'd0, w_half};
        o_misalign  = i_addr_lo[0];
      end
      F3_W: begin
        o_byte_en   = 4'b1111;
        o_load_data = i_rword;
        o_misalign  = (i_addr_lo != 2'b00);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store, stalls the core
// for LATENCY cycles, then pulses resp_valid (and err if rejected) for one cycle.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            stall,
  output logic [XLEN-1:0] rdata,
  output logic            resp_valid,
  output logic            err
);

  localparam int          IDX_W      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0]  LOAD_CNT   = (LATENCY >= 2) ? 4'(LATENCY - 2) : 4'd0;
  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  generate
    if (LATENCY < 1 || LATENCY > 15) begin : g_bad_latency
      $error("data_mem_responder: LATENCY must be within 1..15");
    end
  endgenerate

  state_t            r_state, w_state_nxt;
  logic [3:0]        r_count, w_count_nxt;
  logic [2:0]        r_funct3;
  logic [XLEN-1:0]   r_addr, r_wdata, r_rdata;
  logic              r_mem_read, r_mem_write, r_resp_valid, r_err;
  logic [XLEN-1:0]   r_mem [DEPTH_WORDS];

  logic              w_req, w_idle, w_accept, w_commit, w_err, w_do_write;
  logic              w_cur_rd, w_cur_wr, w_misalign;
  logic [2:0]        w_cur_f3;
  logic [XLEN-1:0]   w_cur_addr, w_cur_wdata, w_rword, w_store_word, w_load_data;
  logic [IDX_W-1:0]  w_word_idx;
  logic [3:0]        w_byte_en;

  assign w_req    = mem_read | mem_write;
  assign w_idle   = (r_state == IDLE);
  assign w_accept = w_idle & w_req;
  assign stall    = w_accept | (r_state == WAIT);

  // With LATENCY==1 the commit edge is also the accept edge, so use live inputs in IDLE.
  assign w_cur_rd    = w_idle ? mem_read  : r_mem_read;
  assign w_cur_wr    = w_idle ? mem_write : r_mem_write;
  assign w_cur_f3    = w_idle ? funct3    : r_funct3;
  assign w_cur_addr  = w_idle ? addr      : r_addr;
  assign w_cur_wdata = w_idle ? wdata     : r_wdata;

  assign w_word_idx = w_cur_addr[IDX_W+1:2];
  assign w_rword    = r_mem[w_word_idx];

  mem_align u_align (
    .i_funct3     (w_cur_f3),
    .i_addr_lo    (w_cur_addr[1:0]),
    .i_wdata      (w_cur_wdata),
    .i_rword      (w_rword),
    .o_byte_en    (w_byte_en),
    .o_store_word (w_store_word),
    .o_load_data  (w_load_data),
    .o_misalign   (w_misalign)
  );

  assign w_err = w_misalign | (w_cur_addr >= ADDR_LIMIT) |
                 ~f3_legal(w_cur_f3, w_cur_wr) | (w_cur_rd & w_cur_wr);

  assign w_commit   = (w_state_nxt == DONE);
  assign w_do_write = w_commit & w_cur_wr & ~w_err & rst_n;

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    case (r_state)
      IDLE: if (w_req) begin
        if (LATENCY == 1) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = WAIT;
          w_count_nxt = LOAD_CNT;
        end
      end
      WAIT: if (r_count == 4'd0) w_state_nxt = DONE;
            else                 w_count_nxt = r_count - 4'd1;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_count      <= 4'd0;
      r_rdata      <= '0;
      r_resp_valid <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_resp_valid <= w_commit;
      r_err        <= w_commit & w_err;
      if (w_commit && (w_err || w_cur_rd))
        r_rdata <= w_err ? '0 : w_load_data;
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_funct3    <= funct3;
      r_addr      <= addr;
      r_wdata     <= wdata;
      r_mem_read  <= mem_read;
      r_mem_write <= mem_write;
    end
  end

  // NOTE: the array has no reset so it maps onto plain RAM; reset only gates the write enable.
  always_ff @(posedge clk) begin
    if (w_do_write) begin
      for (int i = 0; i < 4; i++)
        if (w_byte_en[i]) r_mem[w_word_idx][8*i +: 8] <= w_store_word[8*i +: 8];
    end
  end

  assign rdata      = r_rdata;
  assign resp_valid = r_resp_valid;
  assign err        = r_err;

endmodule
